// File: rtl/clk_mode_ctrl.sv
// rtl/clk_mode_ctrl.sv - debounced push-button run-mode controller for the pipeline clock divider
//
// Purpose:
//   Synchronizes and debounces the speed and pause buttons, then drives a
//   four-state mode FSM whose state register directly decodes to the
//   divider speed select and the pipeline run enable.
//
// Optional feature macro: CLK_MODE_CTRL_STEP_EN
//   When defined, adds a single-step button. A debounced step press while
//   paused produces a one-cycle step_pulse.
//
// Ports:
//   clk_in      in   1  system clock (same clock as the divider)
//   rst_n       in   1  asynchronous active-low reset
//   btn_speed   in   1  raw speed button, active-high, asynchronous
//   btn_pause   in   1  raw pause button, active-high, asynchronous
//   choose      out  1  divider speed select: 1 = fast, 0 = slow
//   run_en      out  1  1 = pipeline clocking enabled, 0 = held
//   mode_led    out  2  {run_en, choose}
//   btn_step    in   1  raw step button (CLK_MODE_CTRL_STEP_EN only)
//   step_pulse  out  1  one-cycle step strobe (CLK_MODE_CTRL_STEP_EN only)

// Per-button 2-flop synchronizer plus saturating debounce counter.
// press_o pulses for one cycle when the accepted level rises.
module clk_mode_ctrl_db #(
  parameter int unsigned DEBOUNCE_CYCLES = 1500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      s1_q          <= btn_i;
      s2_q          <= s1_q;
      stable_prev_q <= stable_q;
      if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Level has disagreed long enough: accept it and restart.
        stable_q <= s2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Rising edge only; releases never generate events.
  assign press_o = stable_q & ~stable_prev_q;

endmodule

module clk_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic       choose,
  output logic       run_en,
  output logic [1:0] mode_led
`ifdef CLK_MODE_CTRL_STEP_EN
  ,
  input  logic       btn_step,
  output logic       step_pulse
`endif
);

  typedef enum logic [1:0] {
    SLOW_RUN   = 2'b00,
    FAST_RUN   = 2'b01,
    SLOW_PAUSE = 2'b10,
    FAST_PAUSE = 2'b11
  } mode_e;

  mode_e state_q, state_d;
  logic  speed_press;
  logic  pause_press;

  clk_mode_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_speed (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .btn_i  (btn_speed),
    .press_o(speed_press)
  );

  clk_mode_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .btn_i  (btn_pause),
    .press_o(pause_press)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOW_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Speed press toggles speed, pause press toggles run/pause; both toggle both.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOW_RUN: begin
        case ({speed_press, pause_press})
          2'b10:   state_d = FAST_RUN;
          2'b01:   state_d = SLOW_PAUSE;
          2'b11:   state_d = FAST_PAUSE;
          default: state_d = SLOW_RUN;
        endcase
      end
      FAST_RUN: begin
        case ({speed_press, pause_press})
          2'b10:   state_d = SLOW_RUN;
          2'b01:   state_d = FAST_PAUSE;
          2'b11:   state_d = SLOW_PAUSE;
          default: state_d = FAST_RUN;
        endcase
      end
      SLOW_PAUSE: begin
        case ({speed_press, pause_press})
          2'b10:   state_d = FAST_PAUSE;
          2'b01:   state_d = SLOW_RUN;
          2'b11:   state_d = FAST_RUN;
          default: state_d = SLOW_PAUSE;
        endcase
      end
      FAST_PAUSE: begin
        case ({speed_press, pause_press})
          2'b10:   state_d = SLOW_PAUSE;
          2'b01:   state_d = FAST_RUN;
          2'b11:   state_d = SLOW_RUN;
          default: state_d = FAST_PAUSE;
        endcase
      end
      default: state_d = SLOW_RUN;
    endcase
  end

  // Outputs come straight from the state register, never from the buttons.
  always_comb begin
    choose = 1'b0;
    run_en = 1'b1;
    case (state_q)
      SLOW_RUN:   begin choose = 1'b0; run_en = 1'b1; end
      FAST_RUN:   begin choose = 1'b1; run_en = 1'b1; end
      SLOW_PAUSE: begin choose = 1'b0; run_en = 1'b0; end
      FAST_PAUSE: begin choose = 1'b1; run_en = 1'b0; end
      default:    begin choose = 1'b0; run_en = 1'b1; end
    endcase
  end

  assign mode_led = {run_en, choose};

`ifdef CLK_MODE_CTRL_STEP_EN
  logic step_press;
  logic step_pulse_q;

  clk_mode_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_step (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .btn_i  (btn_step),
    .press_o(step_press)
  );

  // Steps only make sense while the pipeline is held.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      step_pulse_q <= 1'b0;
    end else begin
      step_pulse_q <= step_press & ((state_q == SLOW_PAUSE) || (state_q == FAST_PAUSE));
    end
  end

  assign step_pulse = step_pulse_q;
`endif

endmodule
